// File: rtl/universal_reg.sv
// -----------------------------------------------------------------------------
// universal_reg
//   General-purpose WIDTH-bit register with synchronous clear/preset and a
//   mode-selected operation: hold, parallel load, shift left/right with serial
//   fill, rotate left/right, and modulo increment/decrement with a one-cycle
//   wrap-around flag.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset (q <= RST_VAL, wrap <= 0)
//   clr    : synchronous clear, highest priority
//   pst    : synchronous preset to PST_VAL, below clr
//   ena    : enables the operation selected by mode
//   mode   : 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror,
//            110 inc, 111 dec
//   d      : parallel load data
//   sin_l  : serial bit entering the MSB on shift right
//   sin_r  : serial bit entering the LSB on shift left
//   q      : registered contents
//   wrap   : registered, high for one cycle after an inc/dec wrap-around
//   zero   : combinational, high when q == 0
// -----------------------------------------------------------------------------
module universal_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] PST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             pst,
    input  logic             ena,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_p0;
    logic             wrap_p0;
    logic [WIDTH-1:0] q_p1;
    logic             wrap_p1;

    // ---- stage 0: next-state selection from current contents and controls ----
    // wrap_p0 defaults low so every non-wrapping edge (clr, pst, hold, other
    // modes) clears the flag, making it a single-cycle pulse.
    always_comb begin
        q_p0    = q_p1;
        wrap_p0 = 1'b0;
        if (clr) begin
            q_p0 = '0;
        end else if (pst) begin
            q_p0 = PST_VAL;
        end else if (ena) begin
            case (mode)
                MODE_HOLD: q_p0 = q_p1;
                MODE_LOAD: q_p0 = d;
                MODE_SHL:  q_p0 = {q_p1[WIDTH-2:0], sin_r};
                MODE_SHR:  q_p0 = {sin_l, q_p1[WIDTH-1:1]};
                MODE_ROL:  q_p0 = {q_p1[WIDTH-2:0], q_p1[WIDTH-1]};
                MODE_ROR:  q_p0 = {q_p1[0], q_p1[WIDTH-1:1]};
                MODE_INC: begin
                    q_p0    = q_p1 + ONE;
                    wrap_p0 = &q_p1;
                end
                MODE_DEC: begin
                    q_p0    = q_p1 - ONE;
                    wrap_p0 = ~|q_p1;
                end
                default:   q_p0 = q_p1;
            endcase
        end
    end

    // ---- stage 1: register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1    <= RST_VAL;
            wrap_p1 <= 1'b0;
        end else begin
            q_p1    <= q_p0;
            wrap_p1 <= wrap_p0;
        end
    end

    assign q    = q_p1;
    assign wrap = wrap_p1;
    assign zero = (q_p1 == '0);

endmodule
